ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with a first-word fall-through output FIFO.
// Optional macro PS2_CAPSLOCK_EN enables caps-lock toggling on the 58 make code.
// Ports:
//   clk, reset (async, active-high)
//   scan_code/scan_valid in
//   ascii_out/ascii_valid/ascii_ready FIFO head and pop
//   shift_state, caps_state, fifo_count, overflow status
module ps2_key_decoder #(
  parameter int         FIFO_DEPTH    = 8,
  parameter bit         EMIT_UNMAPPED = 1'b0,
  parameter logic [7:0] UNMAPPED_CHAR = 8'h2A
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    ascii_out,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic                          shift_state,
  output logic                          caps_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, BREAK, EXT, EXT_BREAK
  } state_t;

  state_t state_q, state_d;
  logic lsh_q, lsh_d;
  logic rsh_q, rsh_d;
  logic caps_q, caps_d;
  logic push;
  logic [7:0] push_ch;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic ovf_q;
  logic pop, acc;

  // Returns {hit, char}; up selects letter case, sh selects the
  // shifted glyph of digit/punctuation keys.
  function automatic logic [8:0] map_make(
    input logic [7:0] c,
    input logic       sh,
    input logic       up
  );
    logic [7:0] lm;
    logic [8:0] r;
    // Clearing bit 5 turns a lowercase letter into uppercase.
    lm = {2'b11, ~up, 5'b11111};
    r  = 9'h000;
    case (c)
      8'h1C: r = {1'b1, 8'h61 & lm};
      8'h32: r = {1'b1, 8'h62 & lm};
      8'h21: r = {1'b1, 8'h63 & lm};
      8'h23: r = {1'b1, 8'h64 & lm};
      8'h24: r = {1'b1, 8'h65 & lm};
      8'h2B: r = {1'b1, 8'h66 & lm};
      8'h34: r = {1'b1, 8'h67 & lm};
      8'h33: r = {1'b1, 8'h68 & lm};
      8'h43: r = {1'b1, 8'h69 & lm};
      8'h3B: r = {1'b1, 8'h6A & lm};
      8'h42: r = {1'b1, 8'h6B & lm};
      8'h4B: r = {1'b1, 8'h6C & lm};
      8'h3A: r = {1'b1, 8'h6D & lm};
      8'h31: r = {1'b1, 8'h6E & lm};
      8'h44: r = {1'b1, 8'h6F & lm};
      8'h4D: r = {1'b1, 8'h70 & lm};
      8'h15: r = {1'b1, 8'h71 & lm};
      8'h2D: r = {1'b1, 8'h72 & lm};
      8'h1B: r = {1'b1, 8'h73 & lm};
      8'h2C: r = {1'b1, 8'h74 & lm};
      8'h3C: r = {1'b1, 8'h75 & lm};
      8'h2A: r = {1'b1, 8'h76 & lm};
      8'h1D: r = {1'b1, 8'h77 & lm};
      8'h22: r = {1'b1, 8'h78 & lm};
      8'h35: r = {1'b1, 8'h79 & lm};
      8'h1A: r = {1'b1, 8'h7A & lm};
      8'h45: r = {1'b1, sh ? 8'h29 : 8'h30};
      8'h16: r = {1'b1, sh ? 8'h21 : 8'h31};
      8'h1E: r = {1'b1, sh ? 8'h40 : 8'h32};
      8'h26: r = {1'b1, sh ? 8'h23 : 8'h33};
      8'h25: r = {1'b1, sh ? 8'h24 : 8'h34};
      8'h2E: r = {1'b1, sh ? 8'h25 : 8'h35};
      8'h36: r = {1'b1, sh ? 8'h5E : 8'h36};
      8'h3D: r = {1'b1, sh ? 8'h26 : 8'h37};
      8'h3E: r = {1'b1, sh ? 8'h2A : 8'h38};
      8'h46: r = {1'b1, sh ? 8'h28 : 8'h39};
      8'h0E: r = {1'b1, sh ? 8'h7E : 8'h60};
      8'h4E: r = {1'b1, sh ? 8'h5F : 8'h2D};
      8'h55: r = {1'b1, sh ? 8'h2B : 8'h3D};
      8'h54: r = {1'b1, sh ? 8'h7B : 8'h5B};
      8'h5B: r = {1'b1, sh ? 8'h7D : 8'h5D};
      8'h5D: r = {1'b1, sh ? 8'h7C : 8'h5C};
      8'h4C: r = {1'b1, sh ? 8'h3A : 8'h3B};
      8'h52: r = {1'b1, sh ? 8'h22 : 8'h27};
      8'h41: r = {1'b1, sh ? 8'h3C : 8'h2C};
      8'h49: r = {1'b1, sh ? 8'h3E : 8'h2E};
      8'h4A: r = {1'b1, sh ? 8'h3F : 8'h2F};
      8'h29: r = 9'h120;
      8'h5A: r = 9'h10A;
      8'h66: r = 9'h108;
      8'h0D: r = 9'h109;
      8'h79: r = 9'h12B;
      8'h7B: r = 9'h12D;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign shift_state = lsh_q | rsh_q;
  assign caps_state  = caps_q;

  always_comb begin
    logic [8:0] m;
    state_d = state_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    caps_d  = caps_q;
    push    = 1'b0;
    push_ch = 8'h00;
    m = map_make(scan_code, shift_state,
                 shift_state ^ caps_state);
    if (scan_valid) begin
      state_d = IDLE;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            scan_code == 8'hF0: state_d = BREAK;
            scan_code == 8'hE0: state_d = EXT;
            scan_code == 8'h12: lsh_d = 1'b1;
            scan_code == 8'h59: rsh_d = 1'b1;
            scan_code == 8'h58: begin
`ifdef PS2_CAPSLOCK_EN
              caps_d = ~caps_q;
`else
              caps_d = 1'b0;
`endif
            end
            default: begin
              if (m[8]) begin
                push    = 1'b1;
                push_ch = m[7:0];
              end else if (EMIT_UNMAPPED) begin
                push    = 1'b1;
                push_ch = UNMAPPED_CHAR;
              end
            end
          endcase
        end
        BREAK: begin
          if (scan_code == 8'h12) lsh_d = 1'b0;
          if (scan_code == 8'h59) rsh_d = 1'b0;
        end
        EXT: begin
          unique case (1'b1)
            scan_code == 8'hF0: state_d = EXT_BREAK;
            scan_code == 8'h5A: begin
              push    = 1'b1;
              push_ch = 8'h0A;
            end
            scan_code == 8'h4A: begin
              push    = 1'b1;
              push_ch = 8'h2F;
            end
            default: ;
          endcase
        end
        EXT_BREAK: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      caps_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      caps_q  <= caps_d;
    end
  end

  assign ascii_valid = (cnt_q != '0);
  assign ascii_out   = ascii_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;
  assign pop = ascii_valid & ascii_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign acc = push & ((cnt_q != DEPTH_C) | pop);

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= push_ch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (acc) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (acc & ~pop) cnt_q <= cnt_q + 1'b1;
      else if (~acc & pop) cnt_q <= cnt_q - 1'b1;
      if (push & ~acc) ovf_q <= 1'b1;
    end
  end

endmodule
